// File: rtl/sd_llfifo_pkg.sv
// Shared types and helpers for the linked-list FIFO read-side scheduler.
package sd_llfifo_pkg;

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam int max_q = 32;

  function automatic int qid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of mask at or after ptr, wrapping modulo n; returns ptr if none set.
  function automatic int rr_pick(input logic [max_q-1:0] mask, input int ptr, input int n);
    int pick;
    int idx;
    pick = ptr;
    for (int i = max_q - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (mask[idx[4:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sd_llfifo_obuf.sv
// Small synchronous FIFO with occupancy count; push on full is ignored unless a pop frees a slot.
module sd_llfifo_obuf #(
  parameter int ent_w = 8,
  parameter int depth = 4,
  parameter int cnt_w = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [ent_w-1:0] din,
  input  logic             pop,
  output logic [ent_w-1:0] dout,
  output logic [cnt_w-1:0] count
);

  localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;

  logic [ent_w-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == cnt_w'(depth));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sd_llfifo_rdsched.sv
// Read-side scheduler: round-robin bursts of rd_req to llfifo queues under credit control,
// with returned words buffered and replayed on a srdy/drdy output.
module sd_llfifo_rdsched
  import sd_llfifo_pkg::*;
#(
  parameter int width      = 8,
  parameter int num_queues = 8,
  parameter int qid_sz     = qid_width(num_queues),
  parameter int max_out    = 4,
  parameter int burst      = 4,
  parameter int req_gap    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [num_queues-1:0] q_en,
  input  logic [num_queues-1:0] q_empty,
  output logic [num_queues-1:0] rd_req,
  input  logic                  c_srdy,
  output logic                  c_drdy,
  input  logic [qid_sz-1:0]     c_qid,
  input  logic [width-1:0]      c_data,
  output logic                  p_srdy,
  input  logic                  p_drdy,
  output logic [qid_sz-1:0]     p_qid,
  output logic [width-1:0]      p_data,
  output logic                  seq_err
);

  localparam int cnt_w  = $clog2(max_out + 1);
  localparam int bcnt_w = $clog2(burst + 1);
  localparam int hold_w = (req_gap > 1) ? $clog2(req_gap) : 1;

  state_t                    state, state_nxt;
  logic [qid_sz-1:0]         cur, cur_nxt;
  logic [qid_sz-1:0]         rr_ptr, rr_ptr_nxt;
  logic [bcnt_w-1:0]         bcnt, bcnt_nxt;
  logic [hold_w-1:0]         holdoff, holdoff_nxt;
  logic [num_queues-1:0]     eligible;
  logic                      cur_elig;
  logic                      issue;
  logic                      credit_ok;
  logic [cnt_w-1:0]          inflight;
  logic [cnt_w-1:0]          occ;
  logic [qid_sz-1:0]         exp_qid;
  logic [qid_sz+width-1:0]   buf_dout;
  logic                      buf_pop;
  logic                      qid_bad;
  logic                      overflow;

  assign eligible  = q_en & ~q_empty;
  assign cur_elig  = eligible[cur];
  assign credit_ok = ({1'b0, inflight} + {1'b0, occ}) < (cnt_w + 1)'(max_out);
  assign rd_req    = issue ? (num_queues'(1) << cur) : '0;
  assign c_drdy    = reset;

  always_comb begin
    state_nxt   = state;
    cur_nxt     = cur;
    bcnt_nxt    = bcnt;
    rr_ptr_nxt  = rr_ptr;
    issue       = 1'b0;
    holdoff_nxt = (holdoff != '0) ? holdoff - 1'b1 : '0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          cur_nxt   = qid_sz'(rr_pick(32'(eligible), int'(rr_ptr), num_queues));
          bcnt_nxt  = '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // Empty flag of cur is only trusted once holdoff has drained.
        issue = (holdoff == '0) & credit_ok & cur_elig & (bcnt != bcnt_w'(burst));
        if (issue) begin
          bcnt_nxt    = bcnt + 1'b1;
          holdoff_nxt = hold_w'(req_gap - 1);
        end
        if ((bcnt == bcnt_w'(burst)) || (!cur_elig && (holdoff == '0))) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (cur == qid_sz'(num_queues - 1)) ? '0 : cur + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cur     <= '0;
      rr_ptr  <= '0;
      bcnt    <= '0;
      holdoff <= '0;
      seq_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cur     <= cur_nxt;
      rr_ptr  <= rr_ptr_nxt;
      bcnt    <= bcnt_nxt;
      holdoff <= holdoff_nxt;
      if (qid_bad || overflow) seq_err <= 1'b1;
    end
  end

  // In-flight qid order; its count is the in-flight credit counter.
  sd_llfifo_obuf #(.ent_w(qid_sz), .depth(max_out), .cnt_w(cnt_w)) u_qfifo (
    .clk   (clk),
    .reset (reset),
    .push  (issue),
    .din   (cur),
    .pop   (c_srdy),
    .dout  (exp_qid),
    .count (inflight)
  );

  assign qid_bad  = c_srdy & ((inflight == '0) | (c_qid != exp_qid));
  assign buf_pop  = p_srdy & p_drdy;
  assign overflow = c_srdy & (occ == cnt_w'(max_out)) & ~buf_pop;

  sd_llfifo_obuf #(.ent_w(qid_sz + width), .depth(max_out), .cnt_w(cnt_w)) u_obuf (
    .clk   (clk),
    .reset (reset),
    .push  (c_srdy),
    .din   ({c_qid, c_data}),
    .pop   (p_drdy),
    .dout  (buf_dout),
    .count (occ)
  );

  assign p_srdy          = (occ != '0);
  assign {p_qid, p_data} = p_srdy ? buf_dout : '0;

endmodule
